load_store_unit: RTL

Initiator side of the data-memory interface: accepts one load or store per transaction from the execute stage, forms the effective address, and drives the word-addressed synchronous data RAM. It sign- or zero-extends loads, and performs read-modify-write for byte and halfword stores because the RAM has no byte enables. It sits between the execute stage and the data memory and reports misaligned or illegal accesses as faults instead of touching memory.

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of the data-memory interface. Accepts one load or store per
// transaction, forms ea = base + sext(offset), and drives a word-addressed
// synchronous RAM (read data valid the cycle after the address). Loads are
// sign/zero-extended; byte/halfword stores are done as read-modify-write
// because the RAM has no byte enables. Misaligned or illegal accesses fault
// without touching memory.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   is_store, funct3         operation kind and size
//   base, offset, store_data rs1, signed 12-bit immediate, rs2
//   resp_valid               one-cycle completion pulse
//   load_data, fault         result, held between responses
//   mem_addr, mem_wren,      word-aligned RAM address (0 when idle),
//   mem_wr_data, mem_rd_data write enable, write word, read word
module load_store_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             is_store,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] base,
   input  logic [11:0]      offset,
   input  logic [WIDTH-1:0] store_data,
   output logic             resp_valid,
   output logic [WIDTH-1:0] load_data,
   output logic             fault,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_wren,
   output logic [WIDTH-1:0] mem_wr_data,
   input  logic [WIDTH-1:0] mem_rd_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   localparam logic [2:0] F_BYTE   = 3'b000;
   localparam logic [2:0] F_HALF   = 3'b001;
   localparam logic [2:0] F_WORD   = 3'b010;
   localparam logic [2:0] F_BYTE_U = 3'b100;
   localparam logic [2:0] F_HALF_U = 3'b101;

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] ea_q, ea_d;
   logic [2:0]       f3_q, f3_d;
   logic             st_q, st_d;
   // Holds store_data after accept, then the merged word after the read.
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] load_data_q, load_data_d;
   logic             fault_q, fault_d;

   logic [WIDTH-1:0] ea;
   logic             req_fault;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [WIDTH-1:0] ext_data;
   logic [WIDTH-1:0] merged;

   always_comb begin
      ea = base + {{(WIDTH-12){offset[11]}}, offset};

      req_fault = 1'b0;
      case (funct3)
         F_BYTE:   req_fault = 1'b0;
         F_HALF:   req_fault = ea[0];
         F_WORD:   req_fault = (ea[1:0] != 2'b00);
         F_BYTE_U: req_fault = is_store;
         F_HALF_U: req_fault = is_store | ea[0];
         default:  req_fault = 1'b1;
      endcase

      byte_sel = mem_rd_data[{ea_q[1:0], 3'b000} +: 8];
      half_sel = mem_rd_data[{ea_q[1], 4'b0000} +: 16];
      case (f3_q)
         F_BYTE:   ext_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
         F_BYTE_U: ext_data = {{(WIDTH-8){1'b0}}, byte_sel};
         F_HALF:   ext_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
         F_HALF_U: ext_data = {{(WIDTH-16){1'b0}}, half_sel};
         default:  ext_data = mem_rd_data;
      endcase

      // Only BYTE and HALF stores reach the merge; lanes outside are kept.
      merged = mem_rd_data;
      if (f3_q == F_BYTE) merged[{ea_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else                merged[{ea_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_comb begin
      state_d     = state_q;
      ea_d        = ea_q;
      f3_d        = f3_q;
      st_d        = st_q;
      wdata_d     = wdata_q;
      load_data_d = load_data_q;
      fault_d     = fault_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               ea_d    = ea;
               f3_d    = funct3;
               st_d    = is_store;
               wdata_d = store_data;
               if (req_fault) begin
                  fault_d     = 1'b1;
                  load_data_d = '0;
                  state_d     = S_RESP;
               end else if (is_store && funct3 == F_WORD) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: begin
            if (st_q) begin
               wdata_d = merged;
               state_d = S_WRITE;
            end else begin
               load_data_d = ext_data;
               fault_d     = 1'b0;
               state_d     = S_RESP;
            end
         end
         S_WRITE: begin
            load_data_d = '0;
            fault_d     = 1'b0;
            state_d     = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ea_q        <= '0;
         f3_q        <= '0;
         st_q        <= 1'b0;
         wdata_q     <= '0;
         load_data_q <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ea_q        <= ea_d;
         f3_q        <= f3_d;
         st_q        <= st_d;
         wdata_q     <= wdata_d;
         load_data_q <= load_data_d;
         fault_q     <= fault_d;
      end
   end

   // Memory outputs decode straight from state so reset kills a write at once.
   assign req_ready   = (state_q == S_IDLE);
   assign resp_valid  = (state_q == S_RESP);
   assign mem_wren    = (state_q == S_WRITE);
   assign mem_addr    = (state_q == S_READ || state_q == S_WRITE) ?
                        {ea_q[WIDTH-1:2], 2'b00} : '0;
   assign mem_wr_data = (state_q == S_WRITE) ? wdata_q : '0;
   assign load_data   = load_data_q;
   assign fault       = fault_q;

endmodule
